// File: rtl/rc_adder_arbiter.sv
// rc_adder_arbiter: round-robin arbiter that time-shares one external 4-bit
// ripple-carry nibble adder among NREQ requesters. Each granted W-bit add
// (W = 4*NIBBLES) runs LSB nibble first, with the carry chained between
// nibbles through carry_reg.
// Optional feature: define ADD_SAT_EN for unsigned saturation of resp_sum
// when the final carry is set.
module rc_adder_arbiter #(
  parameter int NREQ    = 4,
  parameter int NIBBLES = 4,
  parameter int IDW     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*4*NIBBLES-1:0] req_a,
  input  logic [NREQ*4*NIBBLES-1:0] req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [IDW-1:0]            resp_id,
  output logic [4*NIBBLES-1:0]      resp_sum,
  output logic                      resp_cout,
  output logic [3:0]                add_a,
  output logic [3:0]                add_b,
  output logic                      add_cin,
  input  logic [3:0]                add_sum,
  input  logic                      add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // S_GAP is a one-cycle turnaround after the response handshake, so no
  // grant can appear until two cycles after resp_ready is accepted.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_GAP} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [W-1:0]     op_a_reg, op_b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [W-1:0]     sum_reg;

  logic [NREQ-1:0]   req_hi, first_hi, first_all, grant_onehot;
  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    rr_ptr_next;
  logic [NREQ*W-1:0] a_masked, b_masked;
  logic [W-1:0]      a_sel, b_sel;
  logic              any_req;
  logic              last_nibble;

  // Bit mask of requester indices whose binary index has bit b set.
  function automatic logic [NREQ-1:0] idx_mask(input int b);
    logic [NREQ-1:0] m;
    m = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (((i >> b) & 1) != 0) m = m | (NREQ'(1) << i);
    end
    return m;
  endfunction

  // Round-robin: lowest requester at/after rr_ptr wins, else lowest overall.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    localparam logic [NREQ-1:0] LOW_MASK = NREQ'((1 << gi) - 1);
    assign req_hi[gi]    = req_valid[gi] & (IDW'(gi) >= rr_ptr_reg);
    assign first_hi[gi]  = req_hi[gi] & ~|(req_hi & LOW_MASK);
    assign first_all[gi] = req_valid[gi] & ~|(req_valid & LOW_MASK);
    assign a_masked[gi*W +: W] = req_a[gi*W +: W] & {W{grant_onehot[gi]}};
    assign b_masked[gi*W +: W] = req_b[gi*W +: W] & {W{grant_onehot[gi]}};
  end

  assign any_req      = |req_valid;
  assign grant_onehot = (|req_hi) ? first_hi : first_all;

  // One-hot to binary encode of the winning requester.
  for (genvar gi = 0; gi < IDW; gi++) begin : g_enc
    localparam logic [NREQ-1:0] IDX_MASK = idx_mask(gi);
    assign grant_idx[gi] = |(grant_onehot & IDX_MASK);
  end

  assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Fold the one-hot masked operand slices down to the granted operands.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = a_sel | W'(a_masked >> (i * W));
      b_sel = b_sel | W'(b_masked >> (i * W));
    end
  end

  assign last_nibble = (cnt_reg == CW'(NIBBLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_req)     state_next = S_RUN;
      S_RUN:   if (last_nibble) state_next = S_DONE;
      S_DONE:  if (resp_ready)  state_next = S_GAP;
      S_GAP:                    state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the adder sees zeros outside RUN.
  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    case (state_reg)
      S_IDLE: if (!rst) req_ready = grant_onehot;
      S_RUN: begin
        add_a   = op_a_reg[3:0];
        add_b   = op_b_reg[3:0];
        add_cin = carry_reg;
      end
      S_DONE:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Grant bookkeeping, operand shift registers, carry chain and nibble count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (any_req) begin
          op_a_reg   <= a_sel;
          op_b_reg   <= b_sel;
          id_reg     <= grant_idx;
          rr_ptr_reg <= rr_ptr_next;
          carry_reg  <= 1'b0;
          cnt_reg    <= '0;
        end
        S_RUN: begin
          op_a_reg  <= op_a_reg >> 4;
          op_b_reg  <= op_b_reg >> 4;
          carry_reg <= add_cout;
          cnt_reg   <= last_nibble ? '0 : cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One result register per nibble, loaded on its RUN step.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    logic [3:0] nib_reg;
    // Capture the adder sum when the nibble counter reaches this slot.
    always_ff @(posedge clk) begin
      if (rst)
        nib_reg <= 4'd0;
      else if (state_reg == S_RUN && cnt_reg == CW'(gi))
        nib_reg <= add_sum;
    end
    assign sum_reg[gi*4 +: 4] = nib_reg;
  end

  assign resp_id   = id_reg;
  assign resp_cout = carry_reg;
`ifdef ADD_SAT_EN
  assign resp_sum  = carry_reg ? {W{1'b1}} : sum_reg;
`else
  assign resp_sum  = sum_reg;
`endif

endmodule

// File: tb/tb_rc_adder_arbiter.sv
// Directed bench for rc_adder_arbiter with a behavioural nibble adder on the
// add_* port. Build with ADD_SAT_EN defined to exercise saturation.
module tb_rc_adder_arbiter;

  localparam int NREQ = 4;
  localparam int NIB  = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              resp_valid, resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_cout;
  logic [3:0]        add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared 4-bit adder the arbiter drives.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  rc_adder_arbiter #(.NREQ(NREQ), .NIBBLES(NIB), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_cout(resp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADD_SAT_EN
    if (s[W]) return {W{1'b1}};
`endif
    return s[W-1:0];
  endfunction

  task automatic wait_grant(output int gidx, output int waited);
    gidx   = -1;
    waited = 0;
    while (req_ready == '0 && waited < 40) begin
      tick();
      waited++;
    end
    check("grant_seen", {31'd0, |req_ready}, 32'd1);
    check("grant_onehot", $countones(req_ready), 32'd1);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx = i;
  endtask

  // Called at the grant cycle; runs the op through to the handshake.
  task automatic complete_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] es, input logic ec);
    int lat;
    tick();
    req_valid[id] = 1'b0;
    lat = 1;
    check("run_k0_a", add_a, a[3:0]);
    check("run_k0_b", add_b, b[3:0]);
    check("run_k0_cin", add_cin, 0);
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("resp_latency", lat, NIB + 1);
    check("resp_sum", resp_sum, es);
    check("resp_cout", resp_cout, ec);
    check("resp_id", resp_id, id);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
    $display("op id=%0d a=%h b=%h sum=%h cout=%0d", id, a, b, resp_sum, resp_cout);
  endtask

  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic ec);
    int g, n;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id]    = 1'b1;
    #1;
    wait_grant(g, n);
    check("grant_id", g, id);
    complete_op(id, a, b, es, ec);
  endtask

  initial begin
    int g, n, seen;
    int order1 [5] = '{0, 1, 2, 3, 0};
    int order2 [4] = '{2, 3, 0, 2};
    logic [W-1:0] ra, rb, sat_ffff;
    int rid;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_sum", resp_sum, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_cout", resp_cout, 0);
    check("rst_add", {add_a, add_b, add_cin}, 0);
    rst = 1'b0;
    tick();

    // Basic add and carry chain
    run_op(0, 16'h1234, 16'h1111, 16'h2345, 1'b0);
    run_op(3, 16'h0FFF, 16'h0001, 16'h1000, 1'b0);
`ifdef ADD_SAT_EN
    sat_ffff = 16'hFFFF;
`else
    sat_ffff = 16'h0000;
`endif
    run_op(1, 16'hFFFF, 16'h0001, sat_ffff, 1'b1);
    run_op(2, 16'h8000, 16'h7FFF, 16'hFFFF, 1'b0);
    check("idle_add", {add_a, add_b, add_cin}, 0);

    // Fairness: all request, resp_ready held; rr_ptr starts at 3 after id 2.
    // Force rr_ptr back to 0 first by a reset.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = 16'h0100;
    end
    req_valid = 4'b1111; resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, n);
      check("rr_order1", g, order1[k]);
      if (k > 0) check("rr_spacing", n + 1, NIB + 3);
      $display("grant %0d", g);
      tick();
    end
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, n);
      check("rr_order2", g, order2[k]);
      $display("grant %0d", g);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 10; k++) tick();
    resp_ready = 1'b0;

    // Backpressure: rr_ptr is 3, only id 1 requests.
    req_a[1*W +: W] = 16'h0FFF; req_b[1*W +: W] = 16'h0001; req_valid[1] = 1'b1;
    #1;
    wait_grant(g, n);
    check("bp_grant", g, 1);
    tick();
    req_valid[1] = 1'b0;
    n = 1;
    while (!resp_valid && n < 40) begin tick(); n++; end
    check("bp_latency", n, NIB + 1);
    req_a[2*W +: W] = 16'hFFFF; req_b[2*W +: W] = 16'h0001; req_valid[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", resp_valid, 1);
      check("bp_sum", resp_sum, 16'h1000);
      check("bp_id", resp_id, 1);
      check("bp_no_grant", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_gap_valid", resp_valid, 0);
    check("bp_gap_grant", req_ready, 0);
    tick();
    check("bp_grant_after2", req_ready, 4'b0100);
    complete_op(2, 16'hFFFF, 16'h0001, sat_ffff, 1'b1);

    // Reset during RUN k=2; rr_ptr is 3, id 1 requests.
    req_a[1*W +: W] = 16'h00FF; req_b[1*W +: W] = 16'h0001; req_valid[1] = 1'b1;
    #1;
    wait_grant(g, n);
    check("mid_grant", g, 1);
    tick(); req_valid[1] = 1'b0;
    tick();
    tick();
    check("mid_k2_a", add_a, 4'h0);
    check("mid_k2_cin", add_cin, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid) seen = 1;
      tick();
    end
    check("mid_no_resp", seen, 0);
    req_a[0*W +: W] = 16'h8000; req_b[0*W +: W] = 16'h8000;
    req_valid = 4'b1111;
    #1;
    wait_grant(g, n);
    check("mid_next_grant", g, 0);
    req_valid = 4'b0001;
    complete_op(0, 16'h8000, 16'h8000, sat_ffff, 1'b1);

    // Random operands against the a+b model
    for (int k = 0; k < 200; k++) begin
      rid = int'($urandom_range(0, NREQ - 1));
      ra  = W'($urandom);
      rb  = W'($urandom);
      run_op(rid, ra, rb, model_sum(ra, rb), ({1'b0, ra} + {1'b0, rb}) >> W);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
